// File: rtl/barrett_reduce_stream_pkg.sv
// barrett_pkg: width helpers and default configuration
// for the pipelined Barrett reducer.
package barrett_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ID_W_DEF  = 4;

  localparam int XW  = 2 * WIDTH_DEF;
  localparam int RW  = WIDTH_DEF + 2;
  localparam int MUW = WIDTH_DEF + 1;

  // Generic beat record at the default width.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [ID_W_DEF-1:0] id;
    logic [XW-1:0]     x;
    logic [WIDTH_DEF-1:0] m;
    logic [XW+1:0]     mid;
  } stage_t;

  function automatic int xw_of(input int w);
    return 2 * w;
  endfunction

  function automatic int rw_of(input int w);
    return w + 2;
  endfunction

  function automatic int muw_of(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/barrett_reduce_stream_if.sv
// Operand/result stream bundle of the reducer.
// master drives operands and ready_i; slave is the reducer.
interface barrett_reduce_stream_if #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 4
);

  logic               valid_i;
  logic               ready_o;
  logic [2*WIDTH-1:0] x_i;
  logic [WIDTH-1:0]   m_i;
  logic [WIDTH:0]     mu_i;
  logic [ID_W-1:0]    id_i;

  logic               valid_o;
  logic               ready_i;
  logic [WIDTH-1:0]   result_o;
  logic [ID_W-1:0]    id_o;
  logic               err_o;

  modport master (
    output valid_i, x_i, m_i, mu_i, id_i,
    output ready_i,
    input  ready_o,
    input  valid_o, result_o, id_o, err_o
  );

  modport slave (
    input  valid_i, x_i, m_i, mu_i, id_i,
    input  ready_i,
    output ready_o,
    output valid_o, result_o, id_o, err_o
  );

endinterface

// File: rtl/barrett_reduce_stream_correct.sv
// barrett_correct: two cascaded conditional subtracts
// bringing a Barrett remainder below m.
module barrett_correct
  import barrett_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH+1:0] r,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] res
);

  localparam int R_BITS = rw_of(WIDTH);

  logic [R_BITS-1:0] m_ext;
  logic [R_BITS-1:0] t1;

  assign m_ext = {2'b00, m};

  // First subtract, then the second folded into the output.
  always_comb begin
    t1 = r;
    if (r >= m_ext) t1 = r - m_ext;
  end

  assign res = WIDTH'((t1 >= m_ext) ? t1 - m_ext : t1);

endmodule

// File: rtl/barrett_reduce_stream.sv
// barrett_reduce_stream: five-stage Barrett x mod m with
// shared stall, tag passthrough and bad-modulus flag.
module barrett_reduce_stream
  import barrett_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input logic clk_i,
  input logic rst_ni,
  barrett_reduce_stream_if.slave bus
);

  localparam int X_BITS  = xw_of(WIDTH);
  localparam int R_BITS  = rw_of(WIDTH);
  localparam int MU_BITS = muw_of(WIDTH);
  localparam int Q_BITS  = X_BITS + 2;

  logic en;

  // S1
  logic              v1, e1;
  logic [ID_W-1:0]   id1;
  logic [X_BITS-1:0] x1;
  logic [WIDTH-1:0]  m1;
  logic [MU_BITS-1:0] mu1;

  // S2
  logic              v2, e2;
  logic [ID_W-1:0]   id2;
  logic [R_BITS-1:0] xl2;
  logic [WIDTH-1:0]  m2;
  logic [MU_BITS-1:0] q3_2;

  // S3
  logic              v3, e3;
  logic [ID_W-1:0]   id3;
  logic [R_BITS-1:0] xl3;
  logic [WIDTH-1:0]  m3;
  logic [R_BITS-1:0] p3;

  // S4
  logic              v4, e4;
  logic [ID_W-1:0]   id4;
  logic [WIDTH-1:0]  m4;
  logic [R_BITS-1:0] r4;

  // S5 / output
  logic              vo, eo;
  logic [ID_W-1:0]   ido;
  logic [WIDTH-1:0]  reso;

  logic [WIDTH:0]     q1;
  logic [MU_BITS-1:0] q3;
  logic [R_BITS-1:0]  p;
  logic [WIDTH-1:0]   red;

  // A held output freezes the whole pipe; bubbles are kept.
  assign en = !vo || bus.ready_i;
  assign bus.ready_o = en;

  assign q1 = x1[X_BITS-1:WIDTH-1];
  assign q3 = MU_BITS'((Q_BITS'(q1) * Q_BITS'(mu1))
                       >> (WIDTH + 1));
  assign p  = R_BITS'(q3_2) * R_BITS'(m2);

  barrett_correct #(.WIDTH(WIDTH)) u_correct (
    .r   (r4),
    .m   (m4),
    .res (red)
  );

  // S1: capture operand; flag a modulus without its MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1  <= 1'b0;
      e1  <= 1'b0;
      id1 <= '0;
      x1  <= '0;
      m1  <= '0;
      mu1 <= '0;
    end else if (en) begin
      v1  <= bus.valid_i;
      e1  <= ~bus.m_i[WIDTH-1];
      id1 <= bus.id_i;
      x1  <= bus.x_i;
      m1  <= bus.m_i;
      mu1 <= bus.mu_i;
    end
  end

  // S2: quotient estimate q3 = ((x >> k-1) * mu) >> k+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2   <= 1'b0;
      e2   <= 1'b0;
      id2  <= '0;
      xl2  <= '0;
      m2   <= '0;
      q3_2 <= '0;
    end else if (en) begin
      v2   <= v1;
      e2   <= e1;
      id2  <= id1;
      xl2  <= x1[R_BITS-1:0];
      m2   <= m1;
      q3_2 <= q3;
    end
  end

  // S3: low k+2 bits of q3 * m.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3  <= 1'b0;
      e3  <= 1'b0;
      id3 <= '0;
      xl3 <= '0;
      m3  <= '0;
      p3  <= '0;
    end else if (en) begin
      v3  <= v2;
      e3  <= e2;
      id3 <= id2;
      xl3 <= xl2;
      m3  <= m2;
      p3  <= p;
    end
  end

  // S4: remainder mod 2^(k+2), known to be below 3m.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v4  <= 1'b0;
      e4  <= 1'b0;
      id4 <= '0;
      m4  <= '0;
      r4  <= '0;
    end else if (en) begin
      v4  <= v3;
      e4  <= e3;
      id4 <= id3;
      m4  <= m3;
      r4  <= xl3 - p3;
    end
  end

  // S5: corrected result; bad-modulus beats carry zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vo   <= 1'b0;
      eo   <= 1'b0;
      ido  <= '0;
      reso <= '0;
    end else if (en) begin
      vo   <= v4;
      eo   <= e4;
      ido  <= id4;
      reso <= e4 ? '0 : red;
    end
  end

  assign bus.valid_o  = vo;
  assign bus.err_o    = eo;
  assign bus.id_o     = ido;
  assign bus.result_o = reso;

endmodule

// File: tb/tb_barrett_reduce_stream.sv
// Bench for barrett_reduce_stream: directed cases plus
// random streams against a plain-arithmetic mod model.
module tb_barrett_reduce_stream;

  localparam int W  = 32;
  localparam int IW = 4;
  localparam logic [31:0] M_A = 32'h92153525;
  localparam logic [31:0] M_B = 32'hC0000001;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  id;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t exp_q[$];
  logic [31:0] log_res[$];
  logic [3:0]  log_id[$];
  logic        log_err[$];
  int          log_lat[$];
  int          log_cyc[$];

  logic        hold_v = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_id;
  logic        hold_err;

  always #5 clk = ~clk;

  barrett_reduce_stream_if #(.WIDTH(W), .ID_W(IW)) bus ();

  barrett_reduce_stream #(.WIDTH(W), .ID_W(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, req);
    end
  endfunction

  function automatic logic [32:0] calc_mu(input logic [31:0] m);
    logic [64:0] two64;
    two64 = 65'h1 << 64;
    if (m == 32'h0) return '0;
    return 33'(two64 / 65'(m));
  endfunction

  function automatic exp_t model(input logic [63:0] x,
                                 input logic [31:0] m,
                                 input logic [3:0] id);
    exp_t e;
    logic [127:0] q3, r;
    e.id  = id;
    e.acc = cyc;
    e.err = ~m[31];
    e.res = '0;
    if (!e.err) begin
      e.res = 32'(x % 64'(m));
      q3 = ((128'(x) >> 31) * 128'(calc_mu(m))) >> 33;
      r  = 128'(x) - q3 * 128'(m);
      chk("barrett_bound", (r < 3 * 128'(m)) ? 64'd1 : 64'd0,
          64'd1);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      chk("ready_o", 64'(bus.ready_o),
          64'(!bus.valid_o || bus.ready_i));
      if (hold_v) begin
        chk("hold_valid", 64'(bus.valid_o), 64'd1);
        chk("hold_result", 64'(bus.result_o), 64'(hold_res));
        chk("hold_id", 64'(bus.id_o), 64'(hold_id));
        chk("hold_err", 64'(bus.err_o), 64'(hold_err));
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got id 0x%0h, expected none",
                   bus.id_o);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(bus.result_o), 64'(e.res));
          chk("id", 64'(bus.id_o), 64'(e.id));
          chk("err", 64'(bus.err_o), 64'(e.err));
          log_res.push_back(bus.result_o);
          log_id.push_back(bus.id_o);
          log_err.push_back(bus.err_o);
          log_lat.push_back(cyc - e.acc);
          log_cyc.push_back(cyc);
        end
      end
      hold_v   = bus.valid_o && !bus.ready_i;
      hold_res = bus.result_o;
      hold_id  = bus.id_o;
      hold_err = bus.err_o;
      if (bus.valid_i && bus.ready_o)
        exp_q.push_back(model(bus.x_i, bus.m_i, bus.id_i));
    end
  end

  task automatic send(input logic [63:0] x,
                      input logic [31:0] m,
                      input logic [3:0] id);
    logic ok;
    ok = 1'b0;
    bus.valid_i = 1'b1;
    bus.x_i  = x;
    bus.m_i  = m;
    bus.mu_i = calc_mu(m);
    bus.id_i = id;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ready_o;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no ready, expected ready");
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] t1_exp [4];
    logic [63:0] x;
    t1_exp = '{32'h0, 32'h92153524, 32'h0, 32'h92153524};

    bus.valid_i = 1'b0;
    bus.x_i  = '0;
    bus.m_i  = '0;
    bus.mu_i = '0;
    bus.id_i = '0;
    bus.ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_result_o", 64'(bus.result_o), 64'd0);
    chk("rst_id_o", 64'(bus.id_o), 64'd0);
    chk("rst_err_o", 64'(bus.err_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Edge operands, back to back.
    base = log_res.size();
    send(64'h0, M_A, 4'd0);
    send(64'(M_A) - 64'd1, M_A, 4'd1);
    send(64'(M_A), M_A, 4'd2);
    send(64'(M_A) * 64'(M_A) - 64'd1, M_A, 4'd3);
    drain();
    chk("t1_count", 64'(log_res.size() - base), 64'd4);
    if (log_res.size() >= base + 4) begin
      chk("t1_latency", 64'(log_lat[base]), 64'd5);
      for (int i = 0; i < 4; i++) begin
        chk("t1_result", 64'(log_res[base+i]), 64'(t1_exp[i]));
        chk("t1_id", 64'(log_id[base+i]), 64'(i));
        chk("t1_consec", 64'(log_cyc[base+i] - log_cyc[base]),
            64'(i));
      end
    end

    // Largest modulus and operand.
    base = log_res.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 4'd4);
    drain();
    chk("t2_count", 64'(log_res.size() - base), 64'd1);
    if (log_res.size() > base) begin
      chk("t2_result", 64'(log_res[base]), 64'd0);
      chk("t2_err", 64'(log_err[base]), 64'd0);
    end

    // Bad modulus between two good beats.
    base = log_res.size();
    send(64'd100, M_A, 4'd5);
    send(64'd5, 32'h7FFF_FFFF, 4'd6);
    send(64'h1_0000_0000, M_A, 4'd7);
    drain();
    chk("t3_count", 64'(log_res.size() - base), 64'd3);
    if (log_res.size() >= base + 3) begin
      chk("t3_res0", 64'(log_res[base]), 64'd100);
      chk("t3_err0", 64'(log_err[base]), 64'd0);
      chk("t3_res1", 64'(log_res[base+1]), 64'd0);
      chk("t3_err1", 64'(log_err[base+1]), 64'd1);
      chk("t3_id1", 64'(log_id[base+1]), 64'd6);
      chk("t3_res2", 64'(log_res[base+2]), 64'h6DEA_CADB);
      chk("t3_err2", 64'(log_err[base+2]), 64'd0);
    end

    // Random stream with a four-cycle output stall.
    base = log_res.size();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          x = {$urandom(), $urandom()};
          send(x, M_A, 4'(i));
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_ready_o", 64'(bus.ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
      end
    join
    drain();
    chk("t4_count", 64'(log_res.size() - base), 64'd16);
    if (log_res.size() >= base + 16)
      for (int i = 0; i < 16; i++)
        chk("t4_order", 64'(log_id[base+i]), 64'(i));

    // Alternating moduli under random backpressure.
    base = log_res.size();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          x = {$urandom(), $urandom()};
          send(x, (i % 2 == 1) ? M_B : M_A, 4'(i));
        end
      end
      begin
        repeat (30) begin
          bus.ready_i = 1'($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.ready_i = 1'b1;
      end
    join
    drain();
    chk("t5_count", 64'(log_res.size() - base), 64'd12);

    // Reset with beats in flight.
    send(64'd11, M_A, 4'd1);
    send(64'd12, M_A, 4'd2);
    send(64'd13, M_A, 4'd3);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = log_res.size();
    send(64'd7, M_A, 4'hA);
    repeat (15) @(posedge clk);
    #1;
    chk("t6_count", 64'(log_res.size() - base), 64'd1);
    chk("t6_queue", 64'(exp_q.size()), 64'd0);
    if (log_res.size() > base) begin
      chk("t6_result", 64'(log_res[base]), 64'd7);
      chk("t6_id", 64'(log_id[base]), 64'hA);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
